// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding requests to
// instruction memory and registers returned instructions for decode.
module fetch #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            stall_decode,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pc_decode,
    output logic [XLEN-1:0] instr_decode,
    output logic            valid_decode
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic [XLEN-1:0] pc_decode_reg, pc_decode_next;
    logic [XLEN-1:0] instr_decode_reg, instr_decode_next;
    logic            valid_decode_reg, valid_decode_next;
    logic [XLEN-1:0] skid_pc_reg, skid_pc_next;
    logic [XLEN-1:0] skid_instr_reg, skid_instr_next;
    logic            skid_valid_reg, skid_valid_next;

    assign imem_req     = (state_reg == FETCH) && !rst;
    assign imem_addr    = pc_reg & ALIGN_MASK;
    assign pc_decode    = pc_decode_reg;
    assign instr_decode = instr_decode_reg;
    assign valid_decode = valid_decode_reg;

    always_comb begin
        state_next        = state_reg;
        pc_next           = pc_reg;
        pc_decode_next    = pc_decode_reg;
        instr_decode_next = instr_decode_reg;
        valid_decode_next = valid_decode_reg;
        skid_pc_next      = skid_pc_reg;
        skid_instr_next   = skid_instr_reg;
        skid_valid_next   = skid_valid_reg;

        // Without a load, a free decode sees a bubble; a stalled decode keeps its view.
        if (!stall_decode) begin
            valid_decode_next = 1'b0;
            instr_decode_next = NOP_INSTR;
        end

        unique case (state_reg)
            FETCH: begin
                if (imem_ready) state_next = WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    pc_next = pc_reg + PC_STEP;
                    if (!stall_decode) begin
                        pc_decode_next    = pc_reg;
                        instr_decode_next = imem_rdata;
                        valid_decode_next = 1'b1;
                        state_next        = FETCH;
                    end else begin
                        skid_pc_next    = pc_reg;
                        skid_instr_next = imem_rdata;
                        skid_valid_next = 1'b1;
                        state_next      = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!stall_decode) begin
                    pc_decode_next    = skid_pc_reg;
                    instr_decode_next = skid_instr_reg;
                    valid_decode_next = skid_valid_reg;
                    skid_valid_next   = 1'b0;
                    state_next        = FETCH;
                end
            end
            DROP: begin
                if (imem_rvalid) state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase

        // A redirect overrides stall; any request still in flight must be drained in DROP.
        if (redirect_valid) begin
            pc_next           = redirect_pc & ALIGN_MASK;
            valid_decode_next = 1'b0;
            instr_decode_next = NOP_INSTR;
            pc_decode_next    = pc_decode_reg;
            skid_valid_next   = 1'b0;
            if ((state_reg == WAIT && !imem_rvalid) ||
                (state_reg == FETCH && imem_ready) ||
                (state_reg == DROP && !imem_rvalid))
                state_next = DROP;
            else
                state_next = FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= FETCH;
            pc_reg           <= RESET_PC;
            pc_decode_reg    <= '0;
            instr_decode_reg <= NOP_INSTR;
            valid_decode_reg <= 1'b0;
            skid_pc_reg      <= '0;
            skid_instr_reg   <= '0;
            skid_valid_reg   <= 1'b0;
        end else begin
            state_reg        <= state_next;
            pc_reg           <= pc_next;
            pc_decode_reg    <= pc_decode_next;
            instr_decode_reg <= instr_decode_next;
            valid_decode_reg <= valid_decode_next;
            skid_pc_reg      <= skid_pc_next;
            skid_instr_reg   <= skid_instr_next;
            skid_valid_reg   <= skid_valid_next;
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Directed cycle-by-cycle vectors for the fetch stage, plus a hand-written
// variable-latency response sequence.
module tb_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall_decode;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] pc_decode;
    logic [31:0] instr_decode;
    logic        valid_decode;

    int passed = 0;
    int total  = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall_decode(stall_decode),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .pc_decode(pc_decode), .instr_decode(instr_decode), .valid_decode(valid_decode)
    );

    always #5 clk = ~clk;

    // Inputs applied in a cycle and outputs expected during that same cycle.
    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [31:0] rdata;
        logic        stl;
        logic        rd;
        logic [31:0] rdpc;
        logic        req;
        logic [31:0] addr;
        logic [31:0] pcd;
        logic [31:0] instr;
        logic        vld;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic rdy, input logic rv, input logic [31:0] rdata,
                       input logic stl, input logic rd, input logic [31:0] rdpc,
                       input logic req, input logic [31:0] addr, input logic [31:0] pcd,
                       input logic [31:0] instr, input logic vld);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.stl = stl; v.rd = rd; v.rdpc = rdpc;
        v.req = req; v.addr = addr; v.pcd = pcd; v.instr = instr; v.vld = vld;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic rdy, input logic rv, input logic [31:0] rdata,
                         input logic stl, input logic rd, input logic [31:0] rdpc);
        rst = r; imem_ready = rdy; imem_rvalid = rv; imem_rdata = rdata;
        stall_decode = stl; redirect_valid = rd; redirect_pc = rdpc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int waited;
        //   rst rdy rv rdata         stl rd rdpc           req addr          pcd           instr         vld
        add(1, 0, 0, 32'h0,          0, 0, 32'h0,         0, 32'h0,         32'h0,         NOP,          0); // c0
        add(0, 1, 0, 32'h0,          0, 0, 32'h0,         1, 32'h0,         32'h0,         NOP,          0);
        add(0, 0, 1, 32'h00A00093,   0, 0, 32'h0,         0, 32'h0,         32'h0,         NOP,          0);
        add(0, 1, 0, 32'h0,          0, 0, 32'h0,         1, 32'h4,         32'h0,         32'h00A00093, 1);
        add(0, 0, 1, 32'h00100113,   0, 0, 32'h0,         0, 32'h4,         32'h0,         NOP,          0);
        add(0, 1, 0, 32'h0,          1, 0, 32'h0,         1, 32'h8,         32'h4,         32'h00100113, 1); // c5
        add(0, 0, 1, 32'h00200193,   1, 0, 32'h0,         0, 32'h8,         32'h4,         32'h00100113, 1);
        add(0, 0, 0, 32'h0,          1, 0, 32'h0,         0, 32'hC,         32'h4,         32'h00100113, 1);
        add(0, 0, 0, 32'h0,          1, 0, 32'h0,         0, 32'hC,         32'h4,         32'h00100113, 1);
        add(0, 0, 0, 32'h0,          0, 0, 32'h0,         0, 32'hC,         32'h4,         32'h00100113, 1);
        add(0, 0, 0, 32'h0,          0, 0, 32'h0,         1, 32'hC,         32'h8,         32'h00200193, 1); // c10
        add(0, 1, 0, 32'h0,          0, 0, 32'h0,         1, 32'hC,         32'h8,         NOP,          0);
        add(0, 0, 0, 32'h0,          0, 1, 32'h102,       0, 32'hC,         32'h8,         NOP,          0);
        add(0, 0, 1, 32'hDEADBEEF,   0, 0, 32'h0,         0, 32'h100,       32'h8,         NOP,          0);
        add(0, 1, 0, 32'h0,          0, 0, 32'h0,         1, 32'h100,       32'h8,         NOP,          0);
        add(0, 0, 1, 32'h00000033,   0, 0, 32'h0,         0, 32'h100,       32'h8,         NOP,          0); // c15
        add(0, 1, 0, 32'h0,          0, 0, 32'h0,         1, 32'h104,       32'h100,       32'h00000033, 1);
        add(0, 0, 1, 32'h11111111,   0, 1, 32'h200,       0, 32'h104,       32'h100,       NOP,          0);
        add(0, 1, 0, 32'h0,          0, 0, 32'h0,         1, 32'h200,       32'h100,       NOP,          0);
        add(0, 0, 1, 32'h22222222,   0, 0, 32'h0,         0, 32'h200,       32'h100,       NOP,          0);
        add(0, 1, 0, 32'h0,          1, 0, 32'h0,         1, 32'h204,       32'h200,       32'h22222222, 1); // c20
        add(0, 0, 1, 32'h33333333,   1, 1, 32'h300,       0, 32'h204,       32'h200,       32'h22222222, 1);
        add(0, 0, 0, 32'h0,          1, 0, 32'h0,         1, 32'h300,       32'h200,       NOP,          0);
        add(0, 0, 0, 32'h0,          0, 1, 32'hFFFFFFFF,  1, 32'h300,       32'h200,       NOP,          0);
        add(0, 1, 0, 32'h0,          0, 0, 32'h0,         1, 32'hFFFFFFFC,  32'h200,       NOP,          0);
        add(0, 0, 1, 32'h44444444,   0, 0, 32'h0,         0, 32'hFFFFFFFC,  32'h200,       NOP,          0); // c25
        add(0, 1, 0, 32'h0,          0, 0, 32'h0,         1, 32'h0,         32'hFFFFFFFC,  32'h44444444, 1);
        add(0, 0, 1, 32'h55555555,   0, 0, 32'h0,         0, 32'h0,         32'hFFFFFFFC,  NOP,          0);
        add(0, 1, 0, 32'h0,          0, 0, 32'h0,         1, 32'h4,         32'h0,         32'h55555555, 1);
        add(1, 0, 0, 32'h0,          0, 0, 32'h0,         0, 32'h4,         32'h0,         NOP,          0); // rst in WAIT
        add(0, 1, 0, 32'h0,          0, 0, 32'h0,         1, 32'h0,         32'h0,         NOP,          0); // c30
        add(0, 0, 1, 32'h66666666,   1, 0, 32'h0,         0, 32'h0,         32'h0,         NOP,          0);
        add(0, 0, 0, 32'h0,          1, 0, 32'h0,         0, 32'h4,         32'h0,         NOP,          0);
        add(1, 0, 0, 32'h0,          1, 0, 32'h0,         0, 32'h4,         32'h0,         NOP,          0); // rst in HOLD
        add(0, 0, 0, 32'h0,          0, 0, 32'h0,         1, 32'h0,         32'h0,         NOP,          0);
        add(0, 0, 0, 32'h0,          0, 0, 32'h0,         1, 32'h0,         32'h0,         NOP,          0); // c35

        drive(1, 0, 0, 32'h0, 0, 0, 32'h0);
        repeat (2) @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].rdy, tbl[i].rv, tbl[i].rdata, tbl[i].stl, tbl[i].rd, tbl[i].rdpc);
            #1;
            check($sformatf("v%0d imem_req", i),     {31'b0, imem_req},     {31'b0, tbl[i].req});
            check($sformatf("v%0d imem_addr", i),    imem_addr,             tbl[i].addr);
            check($sformatf("v%0d pc_decode", i),    pc_decode,             tbl[i].pcd);
            check($sformatf("v%0d instr_decode", i), instr_decode,          tbl[i].instr);
            check($sformatf("v%0d valid_decode", i), {31'b0, valid_decode}, {31'b0, tbl[i].vld});
        end

        // Slow memory: accept at pc 0, respond after three idle WAIT cycles.
        @(negedge clk);
        drive(0, 1, 0, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("slow wait%0d imem_req", k), {31'b0, imem_req}, 32'h0);
            check($sformatf("slow wait%0d valid", k), {31'b0, valid_decode}, 32'h0);
            @(negedge clk);
        end
        drive(0, 0, 1, 32'h77777777, 0, 0, 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
        waited = 0;
        while (!valid_decode && waited < 5) begin
            @(negedge clk);
            waited++;
        end
        #1;
        check("slow latency", waited, 0);
        check("slow pc_decode", pc_decode, 32'h0);
        check("slow instr_decode", instr_decode, 32'h77777777);
        check("slow next addr", imem_addr, 32'h4);
        check("slow req again", {31'b0, imem_req}, 32'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
